// File: rtl/default_slave.sv
// Default slave for the interconnect: it accepts any read or write that decodes
// to no mapped target and ends it with a DECERR response.
module default_slave #(
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [IDS_BITS-1:0]  arid_i,
    input  logic [LEN_BITS-1:0]  arlen_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,

    output logic [IDS_BITS-1:0]  rid_o,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 rlast_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,

    input  logic [IDS_BITS-1:0]  awid_i,
    input  logic [LEN_BITS-1:0]  awlen_i,
    input  logic                 awvalid_i,
    output logic                 awready_o,

    input  logic                 wlast_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,

    output logic [IDS_BITS-1:0]  bid_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    r_state_e            r_state_q, r_state_d;
    logic [IDS_BITS-1:0] r_id_q,    r_id_d;
    logic [LEN_BITS-1:0] r_len_q,   r_len_d;
    logic [LEN_BITS-1:0] r_cnt_q,   r_cnt_d;
    logic                r_last;

    w_state_e            w_state_q, w_state_d;
    logic [IDS_BITS-1:0] w_id_q,    w_id_d;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // The final beat is detected by equality, so len=15 ends before the counter wraps.
    assign r_last = (r_cnt_q == r_len_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    r_state_d = R_DATA;
                    r_id_d    = arid_i;
                    r_len_d   = arlen_i;
                    r_cnt_d   = '0;
                end
            end
            R_DATA: begin
                if (rready_i) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign arready_o = (r_state_q == R_IDLE);
    assign rvalid_o  = (r_state_q == R_DATA);
    assign rid_o     = rvalid_o ? r_id_q : '0;
    assign rdata_o   = '0;
    assign rresp_o   = rvalid_o ? RESP_DECERR : 2'b00;
    assign rlast_o   = rvalid_o & r_last;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
        end
    end

    // awlen_i is intentionally unused: wlast_i alone closes the burst.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid_i) begin
                    w_state_d = W_DATA;
                    w_id_d    = awid_i;
                end
            end
            W_DATA: begin
                if (wvalid_i && wlast_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awready_o = (w_state_q == W_IDLE);
    assign wready_o  = (w_state_q == W_DATA);
    assign bvalid_o  = (w_state_q == W_RESP);
    assign bid_o     = bvalid_o ? w_id_q : '0;
    assign bresp_o   = bvalid_o ? RESP_DECERR : 2'b00;

    logic unused_awlen;
    assign unused_awlen = ^awlen_i;

endmodule

// File: tb/tb_default_slave.sv
// Directed bench for default_slave: a per-cycle table of inputs and expected
// outputs, plus a hand sequence for the 16-beat read.
module tb_default_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] arid, awid, rid, bid;
    logic [3:0] arlen, awlen;
    logic       arvalid, arready, rlast, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0] rresp, bresp;
    logic       awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    default_slave dut (
        .clk(clk), .rst(rst),
        .arid_i(arid), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready),
        .awid_i(awid), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready),
        .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    );

    typedef struct packed {
        logic       arready;
        logic       rvalid;
        logic [7:0] rid;
        logic       rlast;
        logic [1:0] rresp;
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [7:0] bid;
        logic [1:0] bresp;
    } out_t;

    typedef struct {
        logic       rst;
        logic       arvalid;
        logic [7:0] arid;
        logic [3:0] arlen;
        logic       rready;
        logic       awvalid;
        logic [7:0] awid;
        logic       wvalid;
        logic       wlast;
        logic       bready;
        out_t       exp;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else n_pass++;
    endtask

    // rs: 0=R_IDLE 1=R_DATA; ws: 0=W_IDLE 1=W_DATA 2=W_RESP
    function automatic vec_t mk(input logic r, input logic arv, input logic [7:0] ari,
                                input logic [3:0] arl, input logic rr, input logic awv,
                                input logic [7:0] awi, input logic wv, input logic wl,
                                input logic br, input int rs, input logic [7:0] erid,
                                input logic erl, input int ws, input logic [7:0] ebid);
        vec_t v;
        v.rst = r; v.arvalid = arv; v.arid = ari; v.arlen = arl; v.rready = rr;
        v.awvalid = awv; v.awid = awi; v.wvalid = wv; v.wlast = wl; v.bready = br;
        v.exp.arready = (rs == 0);
        v.exp.rvalid  = (rs == 1);
        v.exp.rid     = (rs == 1) ? erid : 8'h00;
        v.exp.rlast   = (rs == 1) ? erl : 1'b0;
        v.exp.rresp   = (rs == 1) ? 2'b11 : 2'b00;
        v.exp.awready = (ws == 0);
        v.exp.wready  = (ws == 1);
        v.exp.bvalid  = (ws == 2);
        v.exp.bid     = (ws == 2) ? ebid : 8'h00;
        v.exp.bresp   = (ws == 2) ? 2'b11 : 2'b00;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; arvalid = v.arvalid; arid = v.arid; arlen = v.arlen; rready = v.rready;
        awvalid = v.awvalid; awid = v.awid; awlen = 4'h0; wvalid = v.wvalid;
        wlast = v.wlast; bready = v.bready;
    endtask

    task automatic check_out(input string tag, input out_t e);
        check({tag, ".arready"}, 32'(arready), 32'(e.arready));
        check({tag, ".rvalid"},  32'(rvalid),  32'(e.rvalid));
        check({tag, ".rid"},     32'(rid),     32'(e.rid));
        check({tag, ".rlast"},   32'(rlast),   32'(e.rlast));
        check({tag, ".rresp"},   32'(rresp),   32'(e.rresp));
        check({tag, ".rdata"},   rdata,        32'h0);
        check({tag, ".awready"}, 32'(awready), 32'(e.awready));
        check({tag, ".wready"},  32'(wready),  32'(e.wready));
        check({tag, ".bvalid"},  32'(bvalid),  32'(e.bvalid));
        check({tag, ".bid"},     32'(bid),     32'(e.bid));
        check({tag, ".bresp"},   32'(bresp),   32'(e.bresp));
    endtask

    initial begin
        int beats;
        int seen_last;

        //               rst arv arid  len rr awv awid  wv wl br  rs erid  erl ws ebid
        // Read id=12 len=3, rready high: beats on cycles 1..4 after AR.
        vq.push_back(mk(1, 1, 8'h12, 3, 1, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h12, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h12, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h12, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h12, 1, 0, 8'h00));
        // W beat while W_IDLE is ignored; then AW id=21, 2 beats, bready low 2 cycles.
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 8'h21, 0, 0, 0,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 1, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 1, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 2, 8'h21));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 2, 8'h21));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 2, 8'h21));
        // Read len=0, rready low 3 cycles; AR presented during the beat is not taken.
        vq.push_back(mk(1, 1, 8'h5A, 0, 0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,  1, 8'h5A, 1, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,  1, 8'h5A, 1, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,  1, 8'h5A, 1, 0, 8'h00));
        vq.push_back(mk(1, 1, 8'h99, 2, 1, 0, 8'h00, 0, 0, 0,  1, 8'h5A, 1, 0, 8'h00));
        // Simultaneous AR id=33 len=1 and AW id=44, interleaved rready/wvalid.
        vq.push_back(mk(1, 1, 8'h33, 1, 0, 1, 8'h44, 0, 0, 0,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0,  1, 8'h33, 0, 1, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h33, 0, 1, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0,  1, 8'h33, 1, 1, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1,  1, 8'h33, 1, 2, 8'h44));
        // Reset in the middle of a read burst and with a write response pending.
        vq.push_back(mk(1, 1, 8'h77, 7, 0, 1, 8'h66, 0, 0, 0,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h77, 0, 1, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 1, 0,  1, 8'h77, 0, 1, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0,  1, 8'h77, 0, 2, 8'h66));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 8'h00));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 8'h00));

        drive(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00));
        repeat (2) @(posedge clk);

        // Outputs are state-only, so each row is checked mid-cycle before driving it.
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            check_out($sformatf("v%0d", i), vq[i].exp);
            drive(vq[i]);
        end

        // Read id=A5 len=15 with rready high: exactly 16 beats, rlast on the 16th.
        @(negedge clk);
        drive(mk(1, 1, 8'hA5, 15, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00));
        @(negedge clk);
        drive(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00));
        beats = 0;
        seen_last = 0;
        for (int c = 0; c < 40 && !seen_last; c++) begin
            if (rvalid) begin
                check($sformatf("len15.b%0d.rid", beats), 32'(rid), 32'hA5);
                check($sformatf("len15.b%0d.rlast", beats), 32'(rlast), 32'(beats == 15));
                if (rlast) seen_last = 1;
                beats++;
            end
            @(negedge clk);
        end
        check("len15.beats", 32'(beats), 32'd16);
        check("len15.arready_after", 32'(arready), 32'd1);
        check("len15.rvalid_after", 32'(rvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
